// File: rtl/b9_resp_capture.sv
// Change-detecting capture stage for the b9 response: timestamps changes and queues them for a host.
// Optional B9_RESP_MISR_EN adds a MISR signature (sig) over every accepted sample.
module b9_resp_capture #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_word,
    output logic [TS_W-1:0]          out_ts,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef B9_RESP_MISR_EN
    output logic [WIDTH-1:0]         sig,
`endif
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StTrack} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [TS_W-1:0]   ts_q, ts_d;

    logic [WIDTH-1:0]  mem_word_q [DEPTH];
    logic [TS_W-1:0]   mem_ts_q   [DEPTH];
    logic [DEPTH-1:0]  mem_first_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;

    logic push_req, push, pop, full, drop, push_first;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        ts_d       = ts_q;
        push_req   = 1'b0;
        push_first = 1'b0;
        if (clr) begin
            state_d = StIdle;
            prev_d  = '0;
            ts_d    = '0;
        end else if (in_valid) begin
            unique case (state_q)
                StIdle: begin
                    push_req   = 1'b1;
                    push_first = 1'b1;
                end
                StTrack: push_req = (in_word != prev_q);
                default: push_req = 1'b0;
            endcase
            state_d = StTrack;
            prev_d  = in_word;
            ts_d    = ts_q + TS_W'(1);
        end
    end

    assign full = (count_q == FullCnt);
    assign pop  = !clr && (count_q != '0) && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prev_q  <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            ts_q    <= ts_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_word_q[i] <= '0;
                mem_ts_q[i]   <= '0;
            end
            mem_first_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_word_q[wr_ptr_q]  <= in_word;
                mem_ts_q[wr_ptr_q]    <= ts_q;
                mem_first_q[wr_ptr_q] <= push_first;
                wr_ptr_q              <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_word   = mem_word_q[rd_ptr_q];
    assign out_ts     = mem_ts_q[rd_ptr_q];
    assign out_first  = mem_first_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

`ifdef B9_RESP_MISR_EN
    logic [WIDTH-1:0] sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (in_valid) begin
            sig_q <= {sig_q[WIDTH-2:0], sig_q[WIDTH-1] ^ sig_q[1]} ^ in_word;
        end
    end

    assign sig = sig_q;
`endif

endmodule

// File: tb/tb_b9_resp_capture.sv
// Directed bench for b9_resp_capture: vector table plus hand sequences for full, clr, wrap and reset.
module tb_b9_resp_capture;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [20:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_word;
    logic [7:0]  out_ts;
    logic        out_first;
    logic [3:0]  fifo_count;
    logic        overflow;
`ifdef B9_RESP_MISR_EN
    logic [20:0] sig;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    b9_resp_capture #(
        .WIDTH(21),
        .DEPTH(8),
        .TS_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_ts    (out_ts),
        .out_first (out_first),
        .fifo_count(fifo_count),
`ifdef B9_RESP_MISR_EN
        .sig       (sig),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        iv;
        logic [20:0] w;
        logic        rdy;
        logic        ev;
        logic [20:0] ew;
        logic [7:0]  ets;
        logic        ef;
        logic [3:0]  ecnt;
        logic        eovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic c, input logic iv, input logic [20:0] w, input logic rdy);
        clr       = c;
        in_valid  = iv;
        in_word   = w;
        out_ready = rdy;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Head fields are only meaningful while out_valid is expected.
    task automatic check_head(input string tag, input logic ev, input logic [20:0] ew,
                              input logic [7:0] ets, input logic ef, input logic [3:0] ecnt,
                              input logic eovf);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".count"}, 32'(fifo_count), 32'(ecnt));
        check({tag, ".overflow"}, 32'(overflow), 32'(eovf));
        if (ev) begin
            check({tag, ".out_word"}, 32'(out_word), 32'(ew));
            check({tag, ".out_ts"}, 32'(out_ts), 32'(ets));
            check({tag, ".out_first"}, 32'(out_first), 32'(ef));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;

        // clr, iv, w, rdy, ev, ew, ets, ef, ecnt, eovf
        vecs[0]  = '{1'b0, 1'b1, 21'h0A5A5, 1'b0, 1'b1, 21'h0A5A5, 8'd0, 1'b1, 4'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 21'h00000, 1'b1, 1'b0, 21'h00000, 8'd0, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 21'h00000, 1'b0, 1'b0, 21'h00000, 8'd0, 1'b0, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 21'h00001, 1'b0, 1'b1, 21'h00001, 8'd0, 1'b1, 4'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 21'h00001, 1'b0, 1'b1, 21'h00001, 8'd0, 1'b1, 4'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 21'h00001, 1'b0, 1'b1, 21'h00001, 8'd0, 1'b1, 4'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 21'h00001, 1'b0, 1'b1, 21'h00001, 8'd0, 1'b1, 4'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 21'h00001, 1'b0, 1'b1, 21'h00001, 8'd0, 1'b1, 4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 21'h00003, 1'b0, 1'b1, 21'h00001, 8'd0, 1'b1, 4'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 21'h00000, 1'b1, 1'b1, 21'h00003, 8'd5, 1'b0, 4'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 21'h00000, 1'b1, 1'b0, 21'h00000, 8'd0, 1'b0, 4'd0, 1'b0};

        #12;
        check_head("reset", 1'b0, 21'h0, 8'd0, 1'b0, 4'd0, 1'b0);
        check("reset.out_word", 32'(out_word), 32'h0);
`ifdef B9_RESP_MISR_EN
        check("reset.sig", 32'(sig), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].clr, vecs[i].iv, vecs[i].w, vecs[i].rdy);
            check_head($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ew, vecs[i].ets, vecs[i].ef,
                       vecs[i].ecnt, vecs[i].eovf);
        end

        // Overflow: 10 alternating changes into an 8-deep FIFO with no consumer.
        apply(1'b1, 1'b0, 21'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 21'(i % 2), 1'b0);
        end
        check_head("ovf.full", 1'b1, 21'h0, 8'd0, 1'b1, 4'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("ovf.drain%0d", i), 1'b1, 21'(i % 2), 8'(i), (i == 0),
                       4'(8 - i), 1'b1);
            apply(1'b0, 1'b0, 21'h0, 1'b1);
        end
        check_head("ovf.empty", 1'b0, 21'h0, 8'd0, 1'b0, 4'd0, 1'b1);

        // Full with simultaneous pop: push accepted, count held, overflow untouched.
        apply(1'b1, 1'b0, 21'h0, 1'b0);
        check("clr.overflow", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 21'(i % 2), 1'b0);
        end
        check_head("fullpop.pre", 1'b1, 21'h0, 8'd0, 1'b1, 4'd8, 1'b0);
        apply(1'b0, 1'b1, 21'h0, 1'b1);
        check_head("fullpop.post", 1'b1, 21'h1, 8'd1, 1'b0, 4'd8, 1'b0);
        for (int i = 1; i < 9; i++) begin
            check_head($sformatf("fullpop.drain%0d", i), 1'b1, 21'(i % 2), 8'(i), 1'b0,
                       4'(9 - i), 1'b0);
            apply(1'b0, 1'b0, 21'h0, 1'b1);
        end
        check_head("fullpop.empty", 1'b0, 21'h0, 8'd0, 1'b0, 4'd0, 1'b0);

        // clr wins over a same-cycle sample and pop.
        apply(1'b1, 1'b0, 21'h0, 1'b0);
        apply(1'b0, 1'b1, 21'h1, 1'b0);
        apply(1'b0, 1'b1, 21'h2, 1'b0);
        apply(1'b0, 1'b1, 21'h3, 1'b0);
        check_head("clr.pre", 1'b1, 21'h1, 8'd0, 1'b1, 4'd3, 1'b0);
        apply(1'b1, 1'b1, 21'h1FFFFF, 1'b1);
        check_head("clr.post", 1'b0, 21'h0, 8'd0, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b1, 21'h5, 1'b0);
        check_head("clr.next", 1'b1, 21'h5, 8'd0, 1'b1, 4'd1, 1'b0);

        // Timestamp wrap: 256 accepted samples, then a change carries ts 0.
        apply(1'b1, 1'b0, 21'h0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            apply(1'b0, 1'b1, 21'h7, 1'b1);
        end
        check_head("wrap.pre", 1'b0, 21'h0, 8'd0, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b1, 21'h8, 1'b0);
        check_head("wrap.post", 1'b1, 21'h8, 8'd0, 1'b0, 4'd1, 1'b0);

`ifdef B9_RESP_MISR_EN
        apply(1'b1, 1'b0, 21'h0, 1'b1);
        check("misr.clr", 32'(sig), 32'h0);
        apply(1'b0, 1'b1, 21'h1, 1'b1);
        check("misr.s1", 32'(sig), 32'h1);
        apply(1'b0, 1'b1, 21'h2, 1'b1);
        check("misr.s2", 32'(sig), 32'h0);
`endif

        // Async reset mid-operation empties the FIFO without a clock edge.
        apply(1'b0, 1'b1, 21'h9, 1'b0);
        apply(1'b0, 1'b1, 21'hA, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_head("areset", 1'b0, 21'h0, 8'd0, 1'b0, 4'd0, 1'b0);
        check("areset.out_word", 32'(out_word), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b1, 21'h3, 1'b0);
        check_head("areset.next", 1'b1, 21'h3, 8'd0, 1'b1, 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
